fp_multiplier: RTL and testbench

Pipelined IEEE-754 single-precision multiplier that sits directly upstream of the floating-point adder in the chaos-map datapath. It produces products such as r·x and x·(1−x) that the adder consumes, at a rate of one result per cycle. It adds a valid qualifier and exception flags, rounds to nearest-even, and flushes subnormals to zero.

---
 rtl/fp_multiplier.sv | 150 +++++++++++++++
 tb/tb_fp_multiplier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier.sv
// rtl/fp_multiplier.sv - pipelined IEEE-754 single-precision multiplier, RNE rounding, flush-to-zero
// Sampled operands reach result/flags four edges after capture; no backpressure.
module fp_multiplier #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23,
  parameter int BIAS      = 127
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [PRECISION-1:0] a_operand,
  input  logic [PRECISION-1:0] b_operand,
  output logic                 out_valid,
  output logic [PRECISION-1:0] result,
  output logic [2:0]           flags
);
  localparam int MW = FRACTION + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXPONENT + 2;
  localparam logic [EW-1:0] EXP_MAX  = EW'((1 << EXPONENT) - 1);
  localparam logic [EW-1:0] EXP_BIAS = EW'(BIAS);
  localparam logic [PRECISION-1:0] QNAN =
    {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

  // Returns {nan, inf, zero}; any exponent-zero operand is treated as zero.
  function automatic logic [2:0] class_of(input logic [EXPONENT-1:0] e,
                                          input logic [FRACTION-1:0] f);
    logic all_ones;
    all_ones = &e;
    return {all_ones & (|f), all_ones & ~(|f), ~(|e)};
  endfunction

  // Stage registers; class bits are {nan_a, inf_a, zero_a, nan_b, inf_b, zero_b}.
  logic                v1_q, v2_q, v3_q, v4_q;
  logic                sign1_q, sign2_q, sign3_q, sign4_q;
  logic [5:0]          cls1_q, cls2_q, cls3_q, cls4_q;
  logic [EXPONENT-1:0] ea1_q, eb1_q;
  logic [MW-1:0]       ma1_q, mb1_q;
  logic [PW-1:0]       prod2_q, prod2_d;
  logic [EW-1:0]       exp2_q, exp2_d, exp3_q, exp3_d, exp4_q, exp4_d;
  logic [FRACTION-1:0] frac3_q, frac3_d, frac4_q, frac4_d;
  logic                grd3_q, grd3_d, rnd3_q, rnd3_d, stk3_q, stk3_d;
  logic [PRECISION-1:0] result_d;
  logic [2:0]          flags_d;
  logic                inc4, carry4, nan4, inf4, zero4;

  always_comb begin
    prod2_d = PW'(ma1_q) * PW'(mb1_q);
    exp2_d  = {2'b00, ea1_q} + {2'b00, eb1_q} - EXP_BIAS;
  end

  // Hidden bit is always 1 after normalisation, so only the fraction is kept.
  always_comb begin
    if (prod2_q[PW-1]) begin
      frac3_d = prod2_q[PW-2 -: FRACTION];
      grd3_d  = prod2_q[PW-MW-1];
      rnd3_d  = prod2_q[PW-MW-2];
      stk3_d  = |prod2_q[PW-MW-3:0];
      exp3_d  = exp2_q + EW'(1);
    end else begin
      frac3_d = prod2_q[PW-3 -: FRACTION];
      grd3_d  = prod2_q[PW-MW-2];
      rnd3_d  = prod2_q[PW-MW-3];
      stk3_d  = |prod2_q[PW-MW-4:0];
      exp3_d  = exp2_q;
    end
  end

  // An all-ones fraction that rounds up wraps to zero, i.e. mantissa 1.0 with e+1.
  always_comb begin
    inc4    = grd3_q & (rnd3_q | stk3_q | frac3_q[0]);
    carry4  = inc4 & (&frac3_q);
    frac4_d = frac3_q + FRACTION'(inc4);
    exp4_d  = exp3_q + EW'(carry4);
  end

  always_comb begin
    nan4     = cls4_q[5] | cls4_q[2];
    inf4     = cls4_q[4] | cls4_q[1];
    zero4    = cls4_q[3] | cls4_q[0];
    flags_d  = 3'b000;
    result_d = {sign4_q, exp4_q[EXPONENT-1:0], frac4_q};
    if (nan4 || (inf4 && zero4)) begin
      result_d = QNAN;
      flags_d  = 3'b100;
    end else if (inf4) begin
      result_d = {sign4_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    end else if (zero4) begin
      result_d = {sign4_q, {(PRECISION-1){1'b0}}};
    end else if (!exp4_q[EW-1] && exp4_q >= EXP_MAX) begin
      result_d = {sign4_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
      flags_d  = 3'b010;
    end else if (exp4_q[EW-1] || exp4_q == '0) begin
      result_d = {sign4_q, {(PRECISION-1){1'b0}}};
      flags_d  = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
      sign1_q <= 1'b0; sign2_q <= 1'b0; sign3_q <= 1'b0; sign4_q <= 1'b0;
      cls1_q <= '0; cls2_q <= '0; cls3_q <= '0; cls4_q <= '0;
      ea1_q <= '0; eb1_q <= '0; ma1_q <= '0; mb1_q <= '0;
      prod2_q <= '0; exp2_q <= '0; exp3_q <= '0; exp4_q <= '0;
      frac3_q <= '0; frac4_q <= '0;
      grd3_q <= 1'b0; rnd3_q <= 1'b0; stk3_q <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      v1_q    <= in_valid;
      sign1_q <= a_operand[PRECISION-1] ^ b_operand[PRECISION-1];
      ea1_q   <= a_operand[PRECISION-2 -: EXPONENT];
      eb1_q   <= b_operand[PRECISION-2 -: EXPONENT];
      ma1_q   <= {1'b1, a_operand[FRACTION-1:0]};
      mb1_q   <= {1'b1, b_operand[FRACTION-1:0]};
      cls1_q  <= {class_of(a_operand[PRECISION-2 -: EXPONENT], a_operand[FRACTION-1:0]),
                  class_of(b_operand[PRECISION-2 -: EXPONENT], b_operand[FRACTION-1:0])};

      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      cls2_q  <= cls1_q;
      prod2_q <= prod2_d;
      exp2_q  <= exp2_d;

      v3_q    <= v2_q;
      sign3_q <= sign2_q;
      cls3_q  <= cls2_q;
      exp3_q  <= exp3_d;
      frac3_q <= frac3_d;
      grd3_q  <= grd3_d;
      rnd3_q  <= rnd3_d;
      stk3_q  <= stk3_d;

      v4_q    <= v3_q;
      sign4_q <= sign3_q;
      cls4_q  <= cls3_q;
      exp4_q  <= exp4_d;
      frac4_q <= frac4_d;

      out_valid <= v4_q;
      if (v4_q) begin
        result <= result_d;
        flags  <= flags_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_multiplier.sv
// tb/tb_fp_multiplier.sv - scoreboard bench for fp_multiplier with directed and random operands
// Expected values come from a table of known products and an integer-arithmetic reference model.
module tb_fp_multiplier;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        out_valid;
  logic [31:0] result;
  logic [2:0]  flags;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit armed = 1'b0;
  bit rst_seen = 1'b0;
  logic [31:0] last_res = '0;
  logic [2:0]  last_fl = '0;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ta [12] = '{32'h40000000, 32'hC0000000, 32'h3FC00000, 32'h3F800001,
                           32'h3F800001, 32'h7F800000, 32'h7FC00001, 32'hFF800000,
                           32'h00400000, 32'h7F000000, 32'h80800000, 32'h3FFFFFFF};
  logic [31:0] tb [12] = '{32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3FC00000,
                           32'h3F800001, 32'h00000000, 32'h3F800000, 32'h40000000,
                           32'h40000000, 32'h7F000000, 32'h00800000, 32'h3FFFFFFF};
  logic [31:0] tr [12] = '{32'h40C00000, 32'hC0800000, 32'h40100000, 32'h3FC00002,
                           32'h3F800002, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                           32'h00000000, 32'h7F800000, 32'h80000000, 32'h407FFFFE};
  logic [2:0]  tf [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                           3'b100, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000};

  fp_multiplier dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
    if (reset) armed <= 1'b1;
  end

  // Exact product rounded by comparing the discarded remainder against one half.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    bit na = (ea == 255) && (a[22:0] != 0);
    bit nb = (eb == 255) && (b[22:0] != 0);
    bit ia = (ea == 255) && (a[22:0] == 0);
    bit ib = (eb == 255) && (b[22:0] == 0);
    bit za = (ea == 0);
    bit zb = (eb == 0);
    logic s = a[31] ^ b[31];
    longint unsigned p, mant, rem, half;
    int e, sh;
    if (na || nb || (ia && zb) || (ib && za)) return {3'b100, 32'h7FC00000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
    if (za || zb) return {3'b000, s, 31'h0};
    p  = {40'h0, 1'b1, a[22:0]} * {40'h0, 1'b1, b[22:0]};
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end
    mant = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e++;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 15))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2: r[30:23] = 8'hFF;
      3, 4: r[30:23] = 8'($urandom_range(1, 40));
      5, 6: r[30:23] = 8'($urandom_range(200, 254));
      7: r[22:0] = 23'h7FFFFF;
      8: begin r[30:23] = 8'($urandom_range(100, 150)); r[19:0] = '0; end
      default: r[30:23] = 8'($urandom_range(90, 165));
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [2:0] f);
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    sb.push_back('{res: r, fl: f, due: cyc + 5});
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
    logic [34:0] m;
    m = ref_mul(a, b);
    issue(a, b, m[31:0], m[34:32]);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    check("drain timeout", sb.size(), 0);
    repeat (3) idle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (rst_seen) begin
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {29'b0, flags}, 32'd0);
        last_res = '0;
        last_fl  = '0;
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("flags", {29'b0, flags}, {29'b0, e.fl});
          check("latency", cyc, e.due);
          last_res = e.res;
          last_fl  = e.fl;
        end
      end else begin
        check("hold result", result, last_res);
        check("hold flags", {29'b0, flags}, {29'b0, last_fl});
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          check("missing out_valid", {31'b0, out_valid}, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) issue(ta[i], tb[i], tr[i], tf[i]);
    repeat (8) issue_model(rand_op(), rand_op());
    repeat (2) idle();
    repeat (3) issue_model(rand_op(), rand_op());
    drain();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue_model(rand_op(), rand_op());
    end
    drain();

    // Three pairs in flight, then a one-cycle reset that also presents operands.
    repeat (3) issue_model(rand_op(), rand_op());
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b1;
    a_operand = 32'h40000000;
    b_operand = 32'h40000000;
    sb.delete();
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    repeat (4) issue_model(rand_op(), rand_op());
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
